// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory-request unit:
// RV32 width codes, fault codes and the controller state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_BUSERR   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_t;

    // Unused width codes, and any unsigned/extended code on a store, are illegal.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
               (is_store && funct3[2]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering shared by the store path (strobe, replicated data) and
// the load path (lane extraction with sign/zero extension), plus alignment check.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] lane;

    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        wstrb     = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            2'b01: begin
                wstrb     = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                misalign  = addr_lo[0];
            end
            2'b10: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = lane;
                misalign  = |addr_lo;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_req.sv
// Single-outstanding load/store initiator: registered valid/ready memory request,
// lane-extended read result or fault code handed to writeback.
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_store,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_W-1:0]   req_addr,
    output logic                req_wen,
    output logic [DATA_W/8-1:0] req_wstrb,
    output logic [DATA_W-1:0]   req_wdata,
    input  logic                resp_valid,
    output logic                resp_ready,
    input  logic [DATA_W-1:0]   resp_rdata,
    input  logic                resp_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic [1:0]          out_fault
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             is_store_q;
    logic [2:0]       f3_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;
    logic        bad_req;
    logic        tmo_hit;

    // One aligner serves both paths: live inputs while idle, latched request afterwards.
    assign al_funct3  = (state_q == ST_IDLE) ? in_funct3    : f3_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? in_addr[1:0] : addr_lo_q;

    lsu_lane_align u_align (
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wdata     (in_wdata),
        .rdata     (resp_rdata),
        .wstrb     (al_wstrb),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .misalign  (al_misalign)
    );

    assign bad_req = al_misalign || f3_illegal(in_is_store, in_funct3);
    assign tmo_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = bad_req ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready)    state_d = ST_RESP;
                else if (tmo_hit) state_d = ST_DONE;
            end
            ST_RESP: begin
                resp_ready = 1'b1;
                if (resp_valid || tmo_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            f3_q       <= '0;
            addr_lo_q  <= '0;
            cnt_q      <= '0;
            req_addr   <= '0;
            req_wen    <= 1'b0;
            req_wstrb  <= '0;
            req_wdata  <= '0;
            out_rdata  <= '0;
            out_fault  <= FLT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        is_store_q <= in_is_store;
                        f3_q       <= in_funct3;
                        addr_lo_q  <= in_addr[1:0];
                        cnt_q      <= '0;
                        if (bad_req) begin
                            out_rdata <= '0;
                            out_fault <= FLT_MISALIGN;
                        end else begin
                            req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                            req_wen   <= in_is_store;
                            req_wstrb <= in_is_store ? al_wstrb : '0;
                            req_wdata <= in_is_store ? al_wdata : '0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!req_ready && tmo_hit) begin
                        out_rdata <= '0;
                        out_fault <= FLT_TIMEOUT;
                    end
                end
                ST_RESP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A response in the timeout cycle takes precedence over the timeout.
                    if (resp_valid) begin
                        out_fault <= resp_err ? FLT_BUSERR : FLT_NONE;
                        out_rdata <= (resp_err || is_store_q) ? '0 : al_rdata;
                    end else if (tmo_hit) begin
                        out_rdata <= '0;
                        out_fault <= FLT_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed-vector bench for lsu_mem_req with hand-computed expectations.
module tb_lsu_mem_req;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_rdata = '0;
    logic        resp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [1:0]  out_fault;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_mem_req #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_fault(out_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns 1 time unit after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wd;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < max) begin
            tick();
            edges++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp);
        int e;
        req_ready = 1'b1; resp_valid = 1'b1; resp_err = 1'b0; resp_rdata = rd; out_ready = 1'b1;
        issue(1'b0, f3, addr, 32'h0);
        check("ld_req_valid", 32'(req_valid), 32'd1);
        check("ld_req_addr", req_addr, addr & 32'hFFFF_FFFC);
        check("ld_req_wstrb", 32'(req_wstrb), 32'd0);
        check("ld_req_wen", 32'(req_wen), 32'd0);
        wait_out(10, e);
        check("ld_latency", 32'(e), 32'd2);
        check("ld_rdata", out_rdata, exp);
        check("ld_fault", 32'(out_fault), 32'd0);
        check("ld_in_ready_done", 32'(in_ready), 32'd0);
        tick();
        check("ld_back_idle", 32'(in_ready), 32'd1);
        resp_valid = 1'b0;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        int e;
        req_ready = 1'b1; resp_valid = 1'b1; resp_err = 1'b0; resp_rdata = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        issue(1'b1, f3, addr, wd);
        check("st_req_valid", 32'(req_valid), 32'd1);
        check("st_req_addr", req_addr, addr & 32'hFFFF_FFFC);
        check("st_req_wstrb", 32'(req_wstrb), 32'(exp_strb));
        check("st_req_wdata", req_wdata, exp_wd);
        check("st_req_wen", 32'(req_wen), 32'd1);
        wait_out(10, e);
        check("st_latency", 32'(e), 32'd2);
        check("st_rdata", out_rdata, 32'h0);
        check("st_fault", 32'(out_fault), 32'd0);
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic run_fault(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        int e;
        req_ready = 1'b1; resp_valid = 1'b1; resp_err = 1'b0; resp_rdata = 32'h1234_5678;
        out_ready = 1'b1;
        issue(st, f3, addr, 32'hA5A5_A5A5);
        check("flt_no_req", 32'(req_valid), 32'd0);
        wait_out(10, e);
        check("flt_latency", 32'(e), 32'd0);
        check("flt_fault", 32'(out_fault), 32'd1);
        check("flt_rdata", out_rdata, 32'h0);
        tick();
        check("flt_no_req_after", 32'(req_valid), 32'd0);
        check("flt_back_idle", 32'(in_ready), 32'd1);
        resp_valid = 1'b0;
    endtask

    initial begin
        int e;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_resp_ready", 32'(resp_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_rdata", out_rdata, 32'h0);
        check("rst_out_fault", 32'(out_fault), 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_req_wdata", req_wdata, 32'h0);
        check("rst_req_wstrb", 32'(req_wstrb), 32'd0);
        check("rst_req_wen", 32'(req_wen), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Loads: lane extraction and extension
        run_load(3'b000, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load(3'b001, 32'h8000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
        run_load(3'b100, 32'h8000_0001, 32'h80FF_1234, 32'h0000_0012);
        run_load(3'b101, 32'h8000_0000, 32'h80FF_9234, 32'h0000_9234);
        run_load(3'b010, 32'h8000_0004, 32'h80FF_1234, 32'h80FF_1234);
        run_load(3'b000, 32'h0000_0000, 32'h0000_007F, 32'h0000_007F);

        // Stores: strobe and lane replication
        run_store(3'b001, 32'h8000_0102, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        run_store(3'b000, 32'h8000_0001, 32'hDEAD_BEEF, 4'b0010, 32'hEFEF_EFEF);
        run_store(3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned / illegal
        run_fault(1'b0, 3'b010, 32'h8000_0006);
        run_fault(1'b0, 3'b011, 32'h8000_0000);
        run_fault(1'b0, 3'b001, 32'h0000_0001);
        run_fault(1'b1, 3'b010, 32'h0000_0002);
        run_fault(1'b1, 3'b100, 32'h0000_0000);
        run_fault(1'b0, 3'b110, 32'h0000_0000);

        // LHU with request stall then bus error
        req_ready = 1'b0; resp_valid = 1'b1; resp_err = 1'b1; resp_rdata = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        issue(1'b0, 3'b101, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_req_valid", 32'(req_valid), 32'd1);
            check("stall_req_addr", req_addr, 32'h0000_0010);
            check("stall_req_wstrb", 32'(req_wstrb), 32'd0);
            check("stall_req_wen", 32'(req_wen), 32'd0);
            check("stall_resp_ready", 32'(resp_ready), 32'd0);
            if (i < 4) tick();
        end
        req_ready = 1'b1;
        tick();
        check("err_resp_ready", 32'(resp_ready), 32'd1);
        wait_out(10, e);
        check("err_latency", 32'(e), 32'd1);
        check("err_fault", 32'(out_fault), 32'd2);
        check("err_rdata", out_rdata, 32'h0);
        tick();
        resp_valid = 1'b0; resp_err = 1'b0;

        // Timeout, then writeback back-pressure
        req_ready = 1'b1; resp_valid = 1'b0; out_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("tmo_not_yet", 32'(out_valid), 32'd0);
        end
        tick();
        check("tmo_out_valid", 32'(out_valid), 32'd1);
        check("tmo_fault", 32'(out_fault), 32'd3);
        check("tmo_rdata", out_rdata, 32'h0);
        resp_valid = 1'b1; resp_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            check("hold_resp_ready", 32'(resp_ready), 32'd0);
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_fault", 32'(out_fault), 32'd3);
            check("hold_rdata", out_rdata, 32'h0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        resp_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("tmo_back_idle", 32'(in_ready), 32'd1);

        // Response arriving in the timeout cycle wins
        req_ready = 1'b1; resp_valid = 1'b0; out_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        for (int i = 1; i <= 7; i++) tick();
        check("race_not_yet", 32'(out_valid), 32'd0);
        resp_valid = 1'b1; resp_rdata = 32'h1122_3344;
        tick();
        check("race_out_valid", 32'(out_valid), 32'd1);
        check("race_fault", 32'(out_fault), 32'd0);
        check("race_rdata", out_rdata, 32'h1122_3344);
        tick();
        resp_valid = 1'b0;

        // Asynchronous reset while waiting for a response
        req_ready = 1'b1; resp_valid = 1'b0;
        issue(1'b1, 3'b010, 32'h0000_0044, 32'h0BAD_F00D);
        tick();
        check("arst_in_resp", 32'(resp_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_resp_ready", 32'(resp_ready), 32'd0);
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_rdata", out_rdata, 32'h0);
        check("arst_out_fault", 32'(out_fault), 32'd0);
        check("arst_req_addr", req_addr, 32'h0);
        check("arst_req_wdata", req_wdata, 32'h0);
        check("arst_req_wstrb", 32'(req_wstrb), 32'd0);
        check("arst_req_wen", 32'(req_wen), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        resp_valid = 1'b1; resp_rdata = 32'h9999_9999;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_resp_ready", 32'(resp_ready), 32'd0);
        resp_valid = 1'b0;
        run_load(3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "bench did not finish in time");
    end

endmodule
